ps2_device_keyboard_tx: RTL and testbench

//   Device-side PS/2 keyboard transmitter; inverse of the host keyboard interpreter.

---
 rtl/ps2_device_keyboard_tx.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_device_keyboard_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_keyboard_tx.sv
// Device-side PS/2 keyboard transmitter: encodes one key event as E0/F0/key scan-code
// bytes and serialises each as an 11-bit frame while generating the PS/2 clock.
module ps2_device_keyboard_tx #(
    parameter int HALF_PERIOD     = 2000,
    parameter int INHIBIT_HOLDOFF = 2500
) (
    input  logic       clk,
    input  logic       clk__enable,
    input  logic       reset_n,
    input  logic       ps2_key__valid,
    input  logic       ps2_key__extended,
    input  logic       ps2_key__release,
    input  logic [7:0] ps2_key__key_number,
    input  logic       ps2_in__clk,
    input  logic       ps2_in__data,
    output logic       key_ready,
    output logic       ps2_out__clk_low,
    output logic       ps2_out__data_low,
    output logic       frame_done,
    output logic       busy
);

    localparam int CNT_MAX = (HALF_PERIOD > INHIBIT_HOLDOFF) ? HALF_PERIOD : INHIBIT_HOLDOFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(INHIBIT_HOLDOFF - 1);
    localparam logic [3:0]       LAST_BIT  = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLDOFF,
        S_CLK_HIGH,
        S_CLK_LOW,
        S_DONE,
        S_ABORT
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       key_reg;
    logic             pend_e0_reg;
    logic             pend_f0_reg;
    logic             busy_reg;

    logic             accept;
    logic             lines_idle;
    logic             more_bytes;
    logic [7:0]       cur_byte;
    logic [10:0]      frame_bits;
    logic             cur_bit;

    assign accept     = clk__enable & ps2_key__valid & ~busy_reg;
    // A host holding data low (request-to-send) is treated exactly like a clock inhibit.
    assign lines_idle = ps2_in__clk & ps2_in__data;
    // Evaluated during DONE, before the flag of the byte just sent is cleared.
    assign more_bytes = pend_e0_reg | pend_f0_reg;

    always_comb begin
        if (pend_e0_reg) begin
            cur_byte = 8'hE0;
        end else if (pend_f0_reg) begin
            cur_byte = 8'hF0;
        end else begin
            cur_byte = key_reg;
        end
    end

    // Frame layout: start(0), data LSB first, odd parity, stop(1).
    assign frame_bits[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_data_bits
            assign frame_bits[gi+1] = cur_byte[gi];
        end
    endgenerate
    assign frame_bits[9]  = ~^cur_byte;
    assign frame_bits[10] = 1'b1;
    assign cur_bit        = frame_bits[bit_idx_reg];

    // State register and sequence bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            key_reg     <= '0;
            pend_e0_reg <= 1'b0;
            pend_f0_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else if (clk__enable) begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            if (accept) begin
                key_reg     <= ps2_key__key_number;
                pend_e0_reg <= ps2_key__extended;
                pend_f0_reg <= ps2_key__release;
                busy_reg    <= 1'b1;
            end else if (state_reg == S_DONE) begin
                if (pend_e0_reg) begin
                    pend_e0_reg <= 1'b0;
                end else if (pend_f0_reg) begin
                    pend_f0_reg <= 1'b0;
                end else begin
                    busy_reg <= 1'b0;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_HOLDOFF;
                    cnt_next   = '0;
                end
            end
            S_HOLDOFF: begin
                if (!lines_idle) begin
                    cnt_next = '0;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next   = S_CLK_HIGH;
                    cnt_next     = '0;
                    bit_idx_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_CLK_HIGH: begin
                // The first cycle is skipped: the sampled line may still reflect our own low drive.
                if ((cnt_reg != '0) && !ps2_in__clk) begin
                    state_next = S_ABORT;
                    cnt_next   = '0;
                end else if (cnt_reg == HALF_LAST) begin
                    state_next = S_CLK_LOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_CLK_LOW: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next = S_DONE;
                    end else begin
                        state_next   = S_CLK_HIGH;
                        bit_idx_next = bit_idx_reg + 4'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_next   = more_bytes ? S_HOLDOFF : S_IDLE;
                cnt_next     = '0;
                bit_idx_next = '0;
            end
            S_ABORT: begin
                state_next   = S_HOLDOFF;
                cnt_next     = '0;
                bit_idx_next = '0;
            end
            default: begin
                state_next   = S_IDLE;
                cnt_next     = '0;
                bit_idx_next = '0;
            end
        endcase
    end

    // Outputs decode straight from the state so reset releases the lines at once.
    always_comb begin
        ps2_out__clk_low  = 1'b0;
        ps2_out__data_low = 1'b0;
        frame_done        = 1'b0;
        case (state_reg)
            S_CLK_HIGH: begin
                ps2_out__data_low = ~cur_bit;
            end
            S_CLK_LOW: begin
                ps2_out__clk_low  = 1'b1;
                ps2_out__data_low = ~cur_bit;
            end
            S_DONE: begin
                frame_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy      = busy_reg;
    assign key_ready = ~busy_reg;

endmodule

// File: tb/tb_ps2_device_keyboard_tx.sv
// Directed bench for ps2_device_keyboard_tx: a host-side line model decodes frames
// on PS/2 clock falling edges and each scenario task checks its own results.
`timescale 1ns/1ps
module tb_ps2_device_keyboard_tx;

    localparam int HP = 4;
    localparam int HO = 6;
    localparam int LIMIT = 3000;

    logic       clk = 1'b0;
    logic       clk__enable = 1'b1;
    logic       reset_n = 1'b0;
    logic       valid = 1'b0;
    logic       ext = 1'b0;
    logic       rel = 1'b0;
    logic [7:0] key_num = 8'h00;
    logic       host_clk_low = 1'b0;
    logic       host_data_low = 1'b0;
    logic       key_ready, clk_low, data_low, frame_done, busy;
    logic       clk_line, data_line;

    assign clk_line  = ~clk_low & ~host_clk_low;
    assign data_line = ~data_low & ~host_data_low;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;

    int          bit_cnt = 0;
    logic [10:0] acc = '0;
    logic [10:0] frame_q[$];
    int          rise_q[$];
    int          fd_count = 0;
    int          last_fd_cyc = 0;
    logic        prev_clk_line = 1'b1;
    logic        prev_clk_low = 1'b0;

    ps2_device_keyboard_tx #(
        .HALF_PERIOD    (HP),
        .INHIBIT_HOLDOFF(HO)
    ) dut (
        .clk                (clk),
        .clk__enable        (clk__enable),
        .reset_n            (reset_n),
        .ps2_key__valid     (valid),
        .ps2_key__extended  (ext),
        .ps2_key__release   (rel),
        .ps2_key__key_number(key_num),
        .ps2_in__clk        (clk_line),
        .ps2_in__data       (data_line),
        .key_ready          (key_ready),
        .ps2_out__clk_low   (clk_low),
        .ps2_out__data_low  (data_low),
        .frame_done         (frame_done),
        .busy               (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Host-side receiver: samples data on each falling edge of the PS/2 clock line.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n || host_clk_low) begin
                bit_cnt = 0;
            end else if (prev_clk_line && !clk_line) begin
                acc[bit_cnt] = data_line;
                bit_cnt++;
                if (bit_cnt == 11) begin
                    frame_q.push_back(acc);
                    bit_cnt = 0;
                end
            end
            prev_clk_line = clk_line;
            if (clk_low && !prev_clk_low) rise_q.push_back(cyc);
            prev_clk_low = clk_low;
            if (frame_done) begin
                fd_count++;
                last_fd_cyc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] k, input logic e, input logic r);
        int n;
        n = 0;
        key_num = k;
        ext = e;
        rel = r;
        valid = 1'b1;
        while (key_ready !== 1'b1 && n < LIMIT) begin
            tick();
            n++;
        end
        checks++;
        if (n >= LIMIT) begin
            errors++;
            $display("FAIL offer_timeout key=%h key_ready=%b required 1", k, key_ready);
        end
        accept_cyc = cyc + 1;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < LIMIT) begin
            tick();
            n++;
        end
        checks++;
        if (n >= LIMIT) begin
            errors++;
            $display("FAIL %s_idle_timeout busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        int r0;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %b want 1", key_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if ({clk_low, data_low} !== 2'b00) begin errors++; $display("FAIL reset_lines got %b want 00", {clk_low, data_low}); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        r0 = rise_q.size();
        repeat (10) tick();
        checks++;
        if (rise_q.size() != r0) begin errors++; $display("FAIL reset_idle_clock got %0d pulses want 0", rise_q.size() - r0); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int fd0, q0, r0, a;
        fd0 = fd_count; q0 = frame_q.size(); r0 = rise_q.size();
        offer(8'h1C, 1'b0, 1'b0);
        a = accept_cyc;
        checks++;
        if ({busy, key_ready} !== 2'b10) begin errors++; $display("FAIL single_busy_after_accept got %b want 10", {busy, key_ready}); end
        wait_idle("single");
        checks++;
        if (rise_q.size() <= r0) begin errors++; $display("FAIL single_first_clock got none want cycle %0d", a + 10); end
        else if (rise_q[r0] != a + 10) begin errors++; $display("FAIL single_first_clock got cycle %0d want %0d", rise_q[r0], a + 10); end
        checks++;
        if (fd_count - fd0 != 1) begin errors++; $display("FAIL single_frame_done_count got %0d want 1", fd_count - fd0); end
        checks++;
        if (last_fd_cyc != a + 94) begin errors++; $display("FAIL single_frame_done_cycle got %0d want %0d", last_fd_cyc, a + 94); end
        checks++;
        if (frame_q.size() != q0 + 1) begin errors++; $display("FAIL single_frame_count got %0d want 1", frame_q.size() - q0); end
        else if (frame_q[q0] !== 11'h438) begin errors++; $display("FAIL single_frame got %h want 438", frame_q[q0]); end
        checks++;
        if (key_ready !== 1'b1) begin errors++; $display("FAIL single_key_ready_end got %b want 1", key_ready); end
        $display("test_single key=1C frames=%0d", frame_q.size() - q0);
    endtask

    task automatic test_ext_release();
        int fd0, q0, n, busy_low;
        fd0 = fd_count; q0 = frame_q.size();
        offer(8'h75, 1'b1, 1'b1);
        n = 0; busy_low = 0;
        while (fd_count < fd0 + 3 && n < LIMIT) begin
            if (busy !== 1'b1) busy_low++;
            tick();
            n++;
        end
        checks++;
        if (n >= LIMIT) begin errors++; $display("FAIL extrel_timeout got %0d frame_done want 3", fd_count - fd0); end
        checks++;
        if (busy_low != 0) begin errors++; $display("FAIL extrel_busy got %0d low cycles want 0", busy_low); end
        wait_idle("extrel");
        checks++;
        if (fd_count - fd0 != 3) begin errors++; $display("FAIL extrel_frame_done_count got %0d want 3", fd_count - fd0); end
        checks++;
        if (frame_q.size() != q0 + 3) begin errors++; $display("FAIL extrel_frame_count got %0d want 3", frame_q.size() - q0); end
        else if (frame_q[q0] !== 11'h5C0 || frame_q[q0+1] !== 11'h7E0 || frame_q[q0+2] !== 11'h4EA) begin
            errors++;
            $display("FAIL extrel_frames got %h %h %h want 5c0 7e0 4ea", frame_q[q0], frame_q[q0+1], frame_q[q0+2]);
        end
        $display("test_ext_release key=75 E0 F0 frames=%0d", frame_q.size() - q0);
    endtask

    task automatic test_inhibit();
        int fd0, q0, r0, n, rel_cyc;
        fd0 = fd_count; q0 = frame_q.size();
        offer(8'h0C, 1'b0, 1'b0);
        n = 0;
        while (!(bit_cnt == 5 && clk_low === 1'b0) && n < LIMIT) begin
            tick();
            n++;
        end
        checks++;
        if (n >= LIMIT) begin errors++; $display("FAIL inhibit_reach_bit5 got bit_cnt %0d want 5", bit_cnt); end
        tick();
        checks++;
        if ({clk_low, data_low} !== 2'b01) begin errors++; $display("FAIL inhibit_bit5_drive got %b want 01", {clk_low, data_low}); end
        host_clk_low = 1'b1;
        tick();
        checks++;
        if ({clk_low, data_low} !== 2'b00) begin errors++; $display("FAIL inhibit_release got %b want 00", {clk_low, data_low}); end
        repeat (10) tick();
        checks++;
        if (fd_count != fd0) begin errors++; $display("FAIL inhibit_no_frame_done got %0d want 0", fd_count - fd0); end
        host_clk_low = 1'b0;
        rel_cyc = cyc;
        r0 = rise_q.size();
        wait_idle("inhibit");
        checks++;
        if (rise_q.size() <= r0) begin errors++; $display("FAIL inhibit_resend_clock got none want cycle %0d", rel_cyc + 10); end
        else if (rise_q[r0] != rel_cyc + 10) begin errors++; $display("FAIL inhibit_resend_clock got cycle %0d want %0d", rise_q[r0], rel_cyc + 10); end
        checks++;
        if (frame_q.size() != q0 + 1) begin errors++; $display("FAIL inhibit_frame_count got %0d want 1", frame_q.size() - q0); end
        else if (frame_q[q0] !== 11'h618) begin errors++; $display("FAIL inhibit_frame got %h want 618", frame_q[q0]); end
        checks++;
        if (fd_count - fd0 != 1) begin errors++; $display("FAIL inhibit_frame_done_count got %0d want 1", fd_count - fd0); end
        $display("test_inhibit key=0C resent frames=%0d", frame_q.size() - q0);
    endtask

    task automatic test_back_to_back();
        int fd0, q0;
        fd0 = fd_count; q0 = frame_q.size();
        offer(8'h1C, 1'b0, 1'b0);
        key_num = 8'h75; ext = 1'b1; rel = 1'b0; valid = 1'b1;
        checks++;
        if (key_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_while_busy got %b want 0", key_ready); end
        offer(8'h75, 1'b1, 1'b0);
        checks++;
        if (fd_count - fd0 != 1) begin errors++; $display("FAIL b2b_accept_after_first got %0d frame_done want 1", fd_count - fd0); end
        checks++;
        if (accept_cyc != last_fd_cyc + 2) begin errors++; $display("FAIL b2b_accept_cycle got %0d want %0d", accept_cyc, last_fd_cyc + 2); end
        wait_idle("b2b");
        checks++;
        if (frame_q.size() != q0 + 3) begin errors++; $display("FAIL b2b_frame_count got %0d want 3", frame_q.size() - q0); end
        else if (frame_q[q0] !== 11'h438 || frame_q[q0+1] !== 11'h5C0 || frame_q[q0+2] !== 11'h4EA) begin
            errors++;
            $display("FAIL b2b_frames got %h %h %h want 438 5c0 4ea", frame_q[q0], frame_q[q0+1], frame_q[q0+2]);
        end
        $display("test_back_to_back keys=1C,E0-75 frames=%0d", frame_q.size() - q0);
    endtask

    task automatic test_enable_freeze();
        int q0, r0, a;
        q0 = frame_q.size(); r0 = rise_q.size();
        offer(8'h1C, 1'b0, 1'b0);
        a = accept_cyc;
        tick();
        clk__enable = 1'b0;
        repeat (7) tick();
        clk__enable = 1'b1;
        wait_idle("enable");
        checks++;
        if (rise_q.size() <= r0) begin errors++; $display("FAIL enable_first_clock got none want cycle %0d", a + 17); end
        else if (rise_q[r0] != a + 17) begin errors++; $display("FAIL enable_first_clock got cycle %0d want %0d", rise_q[r0], a + 17); end
        checks++;
        if (frame_q.size() != q0 + 1) begin errors++; $display("FAIL enable_frame_count got %0d want 1", frame_q.size() - q0); end
        else if (frame_q[q0] !== 11'h438) begin errors++; $display("FAIL enable_frame got %h want 438", frame_q[q0]); end
        $display("test_enable_freeze key=1C frames=%0d", frame_q.size() - q0);
    endtask

    task automatic test_host_rts();
        int q0, r0, rel_cyc;
        q0 = frame_q.size(); r0 = rise_q.size();
        host_data_low = 1'b1;
        offer(8'h75, 1'b0, 1'b0);
        repeat (19) tick();
        checks++;
        if (rise_q.size() != r0) begin errors++; $display("FAIL rts_no_clock got %0d pulses want 0", rise_q.size() - r0); end
        host_data_low = 1'b0;
        rel_cyc = cyc;
        wait_idle("rts");
        checks++;
        if (rise_q.size() <= r0) begin errors++; $display("FAIL rts_first_clock got none want cycle %0d", rel_cyc + 10); end
        else if (rise_q[r0] != rel_cyc + 10) begin errors++; $display("FAIL rts_first_clock got cycle %0d want %0d", rise_q[r0], rel_cyc + 10); end
        checks++;
        if (frame_q.size() != q0 + 1) begin errors++; $display("FAIL rts_frame_count got %0d want 1", frame_q.size() - q0); end
        else if (frame_q[q0] !== 11'h4EA) begin errors++; $display("FAIL rts_frame got %h want 4ea", frame_q[q0]); end
        $display("test_host_rts key=75 frames=%0d", frame_q.size() - q0);
    endtask

    task automatic test_reset_mid();
        int fd0, r0, n;
        fd0 = fd_count;
        offer(8'h12, 1'b0, 1'b0);
        n = 0;
        while (!(bit_cnt == 5 && clk_low === 1'b1) && n < LIMIT) begin
            tick();
            n++;
        end
        checks++;
        if (n >= LIMIT) begin errors++; $display("FAIL rstmid_reach_bit4 got bit_cnt %0d want 5", bit_cnt); end
        checks++;
        if ({clk_low, data_low} !== 2'b11) begin errors++; $display("FAIL rstmid_bit4_drive got %b want 11", {clk_low, data_low}); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({clk_low, data_low} !== 2'b00) begin errors++; $display("FAIL rstmid_async_release got %b want 00", {clk_low, data_low}); end
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        r0 = rise_q.size();
        checks++;
        if ({key_ready, busy} !== 2'b10) begin errors++; $display("FAIL rstmid_idle got ready,busy=%b want 10", {key_ready, busy}); end
        repeat (20) tick();
        checks++;
        if (rise_q.size() != r0) begin errors++; $display("FAIL rstmid_no_clock got %0d pulses want 0", rise_q.size() - r0); end
        checks++;
        if (fd_count != fd0) begin errors++; $display("FAIL rstmid_no_frame_done got %0d want 0", fd_count - fd0); end
        $display("test_reset_mid key=12 aborted by reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_ext_release();
        test_inhibit();
        test_back_to_back();
        test_enable_freeze();
        test_host_rts();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
